// File: rtl/sha2_round_const_seq.sv
// Handshaked SHA-2 round-constant sequencer: streams K[0]..K[ROUNDS-1] from a register
// and holds the SHA-224/SHA-256 initial hash value selected at the last honoured start.
module sha2_round_const_seq #(
    parameter int ROUNDS = 64,
    parameter int RND_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_224,
    input  logic             abort,
    input  logic             k_ready,
    output logic             k_valid,
    output logic [31:0]      k_t,
    output logic [RND_W-1:0] round,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic [255:0]     iv
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [255:0] IV_256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV_224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [RND_W-1:0] LAST_IDX = RND_W'(ROUNDS - 1);

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        k = 32'h0;
        case (idx)
            6'd0:  k = 32'h428a2f98;
            6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;
            6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;
            6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;
            6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;
            6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;
            6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;
            6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;
            6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;
            6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;
            6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;
            6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;
            6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;
            6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;
            6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;
            6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;
            6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;
            6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;
            6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;
            6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;
            6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;
            6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;
            6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;
            6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;
            6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;
            6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;
            6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;
            6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;
            6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;
            6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;
            6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;
            6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;
            6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    state_t             state_q, state_d;
    logic               k_valid_q, k_valid_d;
    logic [31:0]        k_t_q, k_t_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [255:0]       iv_q, iv_d;
    logic [RND_W-1:0]   round_inc;

    assign round_inc = round_q + RND_W'(1);

    always_comb begin
        state_d   = state_q;
        k_valid_d = k_valid_q;
        k_t_d     = k_t_q;
        round_d   = round_q;
        iv_d      = iv_q;
        // abort outranks every transition, including a start seen in IDLE
        if (abort) begin
            state_d   = IDLE;
            k_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = RUN;
                        round_d   = '0;
                        k_t_d     = k_rom(6'd0);
                        k_valid_d = 1'b1;
                        iv_d      = mode_224 ? IV_224 : IV_256;
                    end
                end
                RUN: begin
                    if (k_valid_q && k_ready) begin
                        if (round_q == LAST_IDX) begin
                            k_valid_d = 1'b0;
                            state_d   = DONE;
                        end else begin
                            round_d = round_inc;
                            k_t_d   = k_rom(6'(round_inc));
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: begin
                    state_d   = IDLE;
                    k_valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_valid_q <= 1'b0;
            k_t_q     <= 32'h0;
            round_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            iv_q      <= IV_256;
        end else begin
            state_q   <= state_d;
            k_valid_q <= k_valid_d;
            k_t_q     <= k_t_d;
            round_q   <= round_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            iv_q      <= iv_d;
        end
    end

    assign k_valid = k_valid_q;
    assign k_t     = k_t_q;
    assign round   = round_q;
    assign last    = k_valid_q && (round_q == LAST_IDX);
    assign busy    = busy_q;
    assign done    = done_q;
    assign iv      = iv_q;

endmodule

// File: tb/tb_sha2_round_const_seq.sv
// Scoreboard bench for sha2_round_const_seq: 64-, 1- and 16-round builds, with K words
// derived from cube roots of primes and compared at every consumer handshake.
module tb_sha2_round_const_seq;

    localparam int R0 = 64;
    localparam int R1 = 1;
    localparam int R2 = 16;
    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_m, mode_m, abort_m, rdy_m;
    logic start_s, mode_s, abort_s, rdy_s;

    logic v_m, last_m, busy_m, done_m;
    logic [31:0] k_m;
    logic [5:0] rnd_m;
    logic [255:0] iv_m;

    logic v_a, last_a, busy_a, done_a;
    logic [31:0] k_a;
    logic [0:0] rnd_a;
    logic [255:0] iv_a;

    logic v_b, last_b, busy_b, done_b;
    logic [31:0] k_b;
    logic [3:0] rnd_b;
    logic [255:0] iv_b;

    sha2_round_const_seq #(.ROUNDS(R0), .RND_W(6)) u_m (
        .clk(clk), .rst(rst), .start(start_m), .mode_224(mode_m), .abort(abort_m),
        .k_ready(rdy_m), .k_valid(v_m), .k_t(k_m), .round(rnd_m), .last(last_m),
        .busy(busy_m), .done(done_m), .iv(iv_m));

    sha2_round_const_seq #(.ROUNDS(R1), .RND_W(1)) u_a (
        .clk(clk), .rst(rst), .start(start_s), .mode_224(mode_s), .abort(abort_s),
        .k_ready(rdy_s), .k_valid(v_a), .k_t(k_a), .round(rnd_a), .last(last_a),
        .busy(busy_a), .done(done_a), .iv(iv_a));

    sha2_round_const_seq #(.ROUNDS(R2), .RND_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start_s), .mode_224(mode_s), .abort(abort_s),
        .k_ready(rdy_s), .k_valid(v_b), .k_t(k_b), .round(rnd_b), .last(last_b),
        .busy(busy_b), .done(done_b), .iv(iv_b));

    typedef struct {
        logic [31:0] k;
        int          idx;
        bit          lst;
    } item_t;

    item_t       exp_q[3][$];
    bit          pend_done[3];
    logic [31:0] kt[64];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fractional part of cbrt(p) to 32 bits, corrected exactly with integer cubes.
    function automatic logic [31:0] kref(input int p);
        real          c;
        logic [127:0] x, t;
        c = $pow(real'(p), 1.0 / 3.0);
        x = 128'(longint'(c * 4294967296.0));
        t = 128'(p) << 96;
        while (x * x * x > t) x = x - 128'd1;
        while ((x + 128'd1) * (x + 128'd1) * (x + 128'd1) <= t) x = x + 128'd1;
        return x[31:0];
    endfunction

    task automatic mon_step(input int id, input logic v, input logic r, input logic d,
                            input logic lst, input logic [31:0] k, input int idx);
        item_t e;
        if (d || pend_done[id]) begin
            chk($sformatf("done_%0d", id), 256'(d), 256'(pend_done[id]));
            pend_done[id] = 1'b0;
        end
        if (v && r) begin
            if (exp_q[id].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_handshake_%0d: got k_t=%0h round=%0d, expected none",
                         id, k, idx);
            end else begin
                e = exp_q[id].pop_front();
                chk($sformatf("k_t_%0d", id), 256'(k), 256'(e.k));
                chk($sformatf("round_%0d", id), 256'(idx), 256'(e.idx));
                chk($sformatf("last_%0d", id), 256'(lst), 256'(e.lst));
                if (e.lst) pend_done[id] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, v_m, rdy_m, done_m, last_m, k_m, int'(rnd_m));
        mon_step(1, v_a, rdy_s, done_a, last_a, k_a, int'(rnd_a));
        mon_step(2, v_b, rdy_s, done_b, last_b, k_b, int'(rnd_b));
    end

    task automatic block64(input bit m, input int pct, input int stall_at,
                           input int abort_at, input int rst_at);
        int           n;
        int           guard;
        item_t        it;
        logic [255:0] ivx;
        ivx = m ? IV224 : IV256;
        @(posedge clk); #1;
        start_m = 1'b1; mode_m = m; rdy_m = 1'b0;
        for (int i = 0; i < R0; i++) begin
            it.k = kt[i]; it.idx = i; it.lst = (i == R0 - 1);
            exp_q[0].push_back(it);
        end
        @(posedge clk); #1;
        start_m = 1'b0;
        chk("valid_after_start", 256'(v_m), 256'(1));
        chk("iv_after_start", iv_m, ivx);
        n = 0;
        guard = 0;
        while (n < R0) begin
            guard++;
            if (guard > 5000) begin
                n_cmp++; n_bad++;
                $display("FAIL block_timeout: got %0d handshakes, expected %0d", n, R0);
                return;
            end
            if (n == stall_at) begin
                rdy_m = 1'b0;
                stall_at = -1;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("stall_k_t", 256'(k_m), 256'(kt[n]));
                    chk("stall_round", 256'(rnd_m), 256'(n));
                    chk("stall_valid", 256'(v_m), 256'(1));
                end
            end
            if (n == abort_at) begin
                chk("pre_abort_k_t", 256'(k_m), 256'(kt[n]));
                rdy_m = 1'b0; abort_m = 1'b1;
                @(posedge clk); #1;
                abort_m = 1'b0;
                exp_q[0].delete();
                chk("abort_valid", 256'(v_m), 256'(0));
                chk("abort_busy", 256'(busy_m), 256'(0));
                chk("abort_last", 256'(last_m), 256'(0));
                chk("abort_iv", iv_m, ivx);
                return;
            end
            if (n == rst_at) begin
                rdy_m = 1'b0; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q[0].delete();
                chk("rst_valid", 256'(v_m), 256'(0));
                chk("rst_round", 256'(rnd_m), 256'(0));
                chk("rst_k_t", 256'(k_m), 256'(0));
                chk("rst_busy", 256'(busy_m), 256'(0));
                chk("rst_iv", iv_m, IV256);
                return;
            end
            rdy_m   = ($urandom_range(0, 99) < pct);
            start_m = ($urandom_range(0, 5) == 0);
            mode_m  = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (rdy_m) n++;
            #1;
        end
        rdy_m = 1'b0; start_m = 1'b1; mode_m = ~m;
        chk("done_busy", 256'(busy_m), 256'(1));
        chk("done_round", 256'(rnd_m), 256'(R0 - 1));
        chk("done_k_t", 256'(k_m), 256'(kt[R0 - 1]));
        @(posedge clk); #1;
        start_m = 1'b0;
        chk("start_in_done_ignored", 256'(v_m), 256'(0));
        chk("idle_busy", 256'(busy_m), 256'(0));
        chk("iv_hold", iv_m, ivx);
    endtask

    task automatic small_run(input int pct);
        int           n;
        int           guard;
        item_t        it;
        bit           m;
        logic [255:0] ivx;
        m = 1'($urandom_range(0, 1));
        ivx = m ? IV224 : IV256;
        @(posedge clk); #1;
        start_s = 1'b1; mode_s = m; rdy_s = 1'b0;
        it.k = kt[0]; it.idx = 0; it.lst = 1'b1;
        exp_q[1].push_back(it);
        for (int i = 0; i < R2; i++) begin
            it.k = kt[i]; it.idx = i; it.lst = (i == R2 - 1);
            exp_q[2].push_back(it);
        end
        @(posedge clk); #1;
        start_s = 1'b0;
        chk("r1_last_first", 256'(last_a), 256'(1));
        chk("r16_last_first", 256'(last_b), 256'(0));
        chk("r1_iv", iv_a, ivx);
        chk("r16_iv", iv_b, ivx);
        n = 0;
        guard = 0;
        while (n < R2 && guard < 5000) begin
            guard++;
            rdy_s = ($urandom_range(0, 99) < pct);
            @(posedge clk);
            if (rdy_s) n++;
            #1;
        end
        chk("r16_handshakes", 256'(n), 256'(R2));
        rdy_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("r1_idle_valid", 256'(v_a), 256'(0));
        chk("r16_idle_valid", 256'(v_b), 256'(0));
        chk("r16_idle_busy", 256'(busy_b), 256'(0));
    endtask

    initial begin
        int p;
        int cnt;
        bit isp;
        rst = 1'b1;
        start_m = 1'b0; mode_m = 1'b0; abort_m = 1'b0; rdy_m = 1'b0;
        start_s = 1'b0; mode_s = 1'b0; abort_s = 1'b0; rdy_s = 1'b0;
        p = 2;
        cnt = 0;
        while (cnt < 64) begin
            isp = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
            if (isp) begin
                kt[cnt] = kref(p);
                cnt++;
            end
            p++;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 256'(v_m), 256'(0));
        chk("reset_k_t", 256'(k_m), 256'(0));
        chk("reset_round", 256'(rnd_m), 256'(0));
        chk("reset_busy", 256'(busy_m), 256'(0));
        chk("reset_done", 256'(done_m), 256'(0));
        chk("reset_last", 256'(last_m), 256'(0));
        chk("reset_iv", iv_m, IV256);
        rst = 1'b0;

        block64(1'b0, 100, -1, -1, -1);
        block64(1'b1, 100, 7, -1, -1);
        block64(1'($urandom_range(0, 1)), 70, -1, 20, -1);
        block64(1'b0, 100, -1, -1, -1);

        @(posedge clk); #1;
        start_m = 1'b1; abort_m = 1'b1; mode_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0; abort_m = 1'b0;
        chk("abort_beats_start_valid", 256'(v_m), 256'(0));
        chk("abort_beats_start_busy", 256'(busy_m), 256'(0));
        chk("abort_beats_start_iv", iv_m, IV256);

        block64(1'b1, 60, -1, -1, 40);
        for (int b = 0; b < 3; b++) block64(1'($urandom_range(0, 1)), 50 + 20 * b, -1, -1, -1);

        small_run(100);
        small_run(60);

        repeat (3) @(posedge clk);
        #1;
        for (int q = 0; q < 3; q++)
            chk($sformatf("queue_drained_%0d", q), 256'(exp_q[q].size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha2_round_const_seq.md
Name: sha2_round_const_seq

Overview:
- Sequenced round-constant and initial-hash-value source for the SHA-2 compression core.
- Replaces free-running index lookup with a handshaked stream of registered round constants, starting at K[0].
- Adds a round-count parameter, a SHA-224/SHA-256 IV mode, stall handling, abort and completion signalling.
- Sits between the top-level hash controller (start/abort/mode) and the compression datapath (K stream consumer).

Parameters:
- ROUNDS, 64, number of constants emitted per block; legal range 1..64; emitted sequence is always K[0]..K[ROUNDS-1].
- RND_W, 6, width of the round index output; must satisfy 2^RND_W >= ROUNDS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a block; honoured only in IDLE.
- mode_224  input  1  IV select, sampled only when start is honoured; 1 = SHA-224, 0 = SHA-256.
- abort  input  1  terminate current sequence; highest priority after rst.
- k_ready  input  1  consumer accepts k_t this cycle.
- k_valid  output  1  k_t/round hold a valid constant.
- k_t  output  32  round constant K[round]; driven from a flop, never from combinational lookup.
- round  output  RND_W  index of the constant currently presented.
- last  output  1  high when k_valid and round == ROUNDS-1.
- busy  output  1  high in RUN or DONE.
- done  output  1  one-cycle pulse after the final handshake.
- iv  output  256  {H0..H7}, big-endian word order; registered; reflects the mode latched at the last honoured start.

Behaviour:
- Reset values, applied on the cycle rst is sampled high, from any state:
  - state = IDLE; k_valid, last, busy, done = 0; k_t = 0; round = 0.
  - iv = SHA-256 IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- Constant table: the standard 64 SHA-256 K words, e.g. K[0]=428a2f98, K[1]=71374491, K[8]=d807aa98, K[63]=c67178f2.
- SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 (abort=0) -> RUN next cycle. Same edge: round <= 0, k_t <= K[0], k_valid <= 1, iv <= IV(mode_224). Latency start -> k_valid is 1 cycle.
  - RUN, handshake (k_valid & k_ready) with round < ROUNDS-1: round <= round+1, k_t <= K[round+1]. Back-to-back handshakes give one constant per cycle.
  - RUN, no handshake (k_ready=0): k_t, round and k_valid hold unchanged for any number of cycles.
  - RUN, handshake with round == ROUNDS-1: k_valid <= 0 -> DONE.
  - DONE: done=1 for exactly this cycle, busy=1 -> IDLE next cycle. round stays at ROUNDS-1; k_t holds its last value.
- start outside IDLE is ignored: no restart, no mode resample.
- abort, any state: next cycle IDLE, k_valid=0, last=0, busy=0, no done pulse; iv retained. abort together with start in IDLE: abort wins, stay IDLE.
- rst mid-RUN: all outputs return to reset values on the next edge, iv included.
- ROUNDS=1: a single handshake on K[0] goes straight to DONE; last is high on the first valid cycle.
- last is combinational from registered state only: k_valid & (round == ROUNDS-1).
- Index arithmetic is RND_W bits unsigned; round never exceeds ROUNDS-1, so there is no wrap.

Test Plan:
- Reset then start with mode_224=0, k_ready tied high -> k_valid rises 1 cycle after start; k_t sequence 428a2f98, 71374491, b5c0fbcf, ... c67178f2 over 64 consecutive cycles; last only with c67178f2; done pulses once the cycle after; iv = 6a09e667...5be0cd19.
- start with mode_224=1 -> iv = c1059ed8...befa4fa4 from the cycle after start; flip mode_224 mid-run -> iv unchanged.
- k_ready low for 3 cycles at round 7 -> k_t=ab1c5ed5 and round=7 held through the stall; after release the next value is d807aa98; total constants still 64.
- abort at round 20 (k_t=2de92c6f) -> next cycle k_valid=0, busy=0, no done; a new start restarts at K[0]=428a2f98.
- start pulsed during RUN, and rst asserted at round 40 -> start has no effect; rst gives k_valid=0, round=0, k_t=0 and SHA-256 iv on the next edge.
- ROUNDS=1 and ROUNDS=16 builds -> only K[0], or K[0]..K[15] ending at c19bf174 with last; done follows the final handshake.
